// File: rtl/pkt_ff_rptr.sv
// Read-side pointer and egress logic of the async packet FIFO.
// It synchronizes the write pointer, issues RAM reads and streams words through a 2-entry prefetch buffer.
//
// state     | meaning
// ----------+--------------------------------------------
// ST_IDLE   | between packets, next popped word must be SOP
// ST_IN_PKT | inside a packet, waiting for EOP
module pkt_ff_rptr #(
    parameter int PTR_W  = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PTR_W-1:0]  wptr_gry_async,
    output logic [PTR_W-1:0]  rptr_gry,
    output logic              mem_rd_en,
    output logic [PTR_W-1:0]  mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_sop,
    input  logic              mem_rd_eop,
    output logic              valid,
    output logic              sop,
    output logic              eop,
    output logic [DATA_W-1:0] data,
    input  logic              ready,
    output logic              empty,
    output logic [PTR_W-1:0]  occ,
    output logic              frm_err,
    input  logic              clr_err
);

    typedef enum logic {ST_IDLE, ST_IN_PKT} state_t;

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [DATA_W-1:0] data;
    } ent_t;

    function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
        logic [PTR_W-1:0] b;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PTR_W-1:0] wsync1_q, wsync2_q;
    logic [PTR_W-1:0] wptr_bin;
    logic [PTR_W-1:0] rptr_bin_q, rptr_bin_d;
    logic [PTR_W-1:0] rptr_gry_q;
    logic             inflight_q;
    ent_t             ent0_q, ent0_d, ent1_q, ent1_d, new_ent;
    logic [1:0]       buf_cnt_q, buf_cnt_d;
    logic [2:0]       pend;
    logic             pop;
    state_t           state_q, state_d;
    logic             err_set;
    logic             frm_err_q, frm_err_d;

    assign wptr_bin = gray2bin(wsync2_q);
    assign empty    = (wptr_bin == rptr_bin_q);
    assign occ      = wptr_bin - rptr_bin_q;

    assign valid = (buf_cnt_q != 2'd0);
    assign pop   = valid & ready;
    assign sop   = ent0_q.sop;
    assign eop   = ent0_q.eop;
    assign data  = ent0_q.data;

    // Words already buffered or on their way, after this cycle's pop, must leave room for one more.
    assign pend        = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign mem_rd_en   = ~empty & (pend < 3'd2);
    assign mem_rd_addr = rptr_bin_q;
    assign rptr_bin_d  = mem_rd_en ? rptr_bin_q + {{(PTR_W-1){1'b0}}, 1'b1} : rptr_bin_q;
    assign rptr_gry    = rptr_gry_q;
    assign frm_err     = frm_err_q;

    assign new_ent = '{sop: mem_rd_sop, eop: mem_rd_eop, data: mem_rd_data};

    always_comb begin
        ent0_d    = ent0_q;
        ent1_d    = ent1_q;
        buf_cnt_d = buf_cnt_q;
        case ({inflight_q, pop})
            2'b10: begin
                if (buf_cnt_q == 2'd0) ent0_d = new_ent;
                else                   ent1_d = new_ent;
                buf_cnt_d = buf_cnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d    = ent1_q;
                buf_cnt_d = buf_cnt_q - 2'd1;
            end
            2'b11: begin
                if (buf_cnt_q == 2'd2) begin
                    ent0_d = ent1_q;
                    ent1_d = new_ent;
                end else begin
                    ent0_d = new_ent;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        if (pop) begin
            case (state_q)
                ST_IDLE: begin
                    err_set = ~ent0_q.sop;
                    if (ent0_q.sop & ~ent0_q.eop) state_d = ST_IN_PKT;
                end
                ST_IN_PKT: begin
                    err_set = ent0_q.sop;
                    state_d = ent0_q.eop ? ST_IDLE : ST_IN_PKT;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        // A new error outranks a simultaneous clear.
        if (err_set)      frm_err_d = 1'b1;
        else if (clr_err) frm_err_d = 1'b0;
        else              frm_err_d = frm_err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wsync1_q   <= '0;
            wsync2_q   <= '0;
            rptr_bin_q <= '0;
            rptr_gry_q <= '0;
            inflight_q <= 1'b0;
            ent0_q     <= '0;
            ent1_q     <= '0;
            buf_cnt_q  <= 2'd0;
            state_q    <= ST_IDLE;
            frm_err_q  <= 1'b0;
        end else begin
            wsync1_q   <= wptr_gry_async;
            wsync2_q   <= wsync1_q;
            rptr_bin_q <= rptr_bin_d;
            rptr_gry_q <= rptr_bin_d ^ (rptr_bin_d >> 1);
            inflight_q <= mem_rd_en;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            buf_cnt_q  <= buf_cnt_d;
            state_q    <= state_d;
            frm_err_q  <= frm_err_d;
        end
    end

endmodule

// File: tb/tb_pkt_ff_rptr.sv
// Self-checking bench for pkt_ff_rptr: behavioural RAM and write side, queue-based reference model.
module tb_pkt_ff_rptr;
    localparam int PTR_W  = 8;
    localparam int DATA_W = 32;

    logic              clk, rst_n;
    logic [PTR_W-1:0]  wptr_gry_async, rptr_gry, mem_rd_addr, occ;
    logic              mem_rd_en, mem_rd_sop, mem_rd_eop;
    logic [DATA_W-1:0] mem_rd_data, data;
    logic              valid, sop, eop, ready, empty, frm_err, clr_err;

    pkt_ff_rptr #(.PTR_W(PTR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .wptr_gry_async(wptr_gry_async), .rptr_gry(rptr_gry),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_rd_sop(mem_rd_sop), .mem_rd_eop(mem_rd_eop), .valid(valid), .sop(sop),
        .eop(eop), .data(data), .ready(ready), .empty(empty), .occ(occ),
        .frm_err(frm_err), .clr_err(clr_err)
    );

    typedef struct {
        logic              s;
        logic              e;
        logic [DATA_W-1:0] d;
    } word_t;

    logic [DATA_W-1:0] ram_d [256];
    logic              ram_s [256];
    logic              ram_e [256];
    word_t             exp_q [$];
    int                checks = 0, errors = 0;
    int                rd_cnt = 0, pop_cnt = 0;
    logic [PTR_W-1:0]  wbin = '0, w1, w2, exp_raddr = '0, prev_gry = '0, m_occ;
    bit                mon_en = 0, exp_frm = 0, in_pkt = 0, m_err;
    logic [7:0]        rd_hist, val_hist;
    word_t             m_w;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural dual-port RAM read port, 1-cycle latency.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= ram_d[mem_rd_addr];
            mem_rd_sop  <= ram_s[mem_rd_addr];
            mem_rd_eop  <= ram_e[mem_rd_addr];
        end
    end

    // Committed write pointer becomes visible to the read side two clocks later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w1 <= '0;
            w2 <= '0;
        end else begin
            w1 <= wbin;
            w2 <= w1;
        end
    end

    // Reference model: reads in address order, pops in commit order, framing from packet rules.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            m_occ = w2 - exp_raddr;
            chk("occ", 64'(occ), 64'(m_occ));
            chk("empty", 64'(empty), 64'(w2 == exp_raddr));
            chk("frm_err", 64'(frm_err), 64'(exp_frm));
            chk("rptr_gry", 64'(rptr_gry), 64'(exp_raddr ^ (exp_raddr >> 1)));
            if (rptr_gry !== prev_gry)
                chk("gray_step", 64'($countones(rptr_gry ^ prev_gry)), 64'(1));
            prev_gry = rptr_gry;
            if (mem_rd_en) begin
                chk("rd_addr", 64'(mem_rd_addr), 64'(exp_raddr));
                exp_raddr++;
                rd_cnt++;
            end
            m_err = 1'b0;
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", 64'(valid), 64'(0));
                end else begin
                    m_w = exp_q.pop_front();
                    chk("pop_data", 64'(data), 64'(m_w.d));
                    chk("pop_sop", 64'(sop), 64'(m_w.s));
                    chk("pop_eop", 64'(eop), 64'(m_w.e));
                    m_err  = m_w.s ? in_pkt : !in_pkt;
                    in_pkt = (m_w.s | in_pkt) & !m_w.e;
                    pop_cnt++;
                end
            end
            exp_frm = m_err ? 1'b1 : (clr_err ? 1'b0 : exp_frm);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put(input logic s, input logic e);
        logic [DATA_W-1:0] d;
        d = $urandom;
        ram_d[wbin] = d;
        ram_s[wbin] = s;
        ram_e[wbin] = e;
        exp_q.push_back('{s: s, e: e, d: d});
        wbin++;
    endtask

    task automatic publish();
        wptr_gry_async = wbin ^ (wbin >> 1);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        ready = 1'b1;
        while (k < budget && !(exp_q.size() == 0 && w2 == wbin && w2 == exp_raddr && !valid)) begin
            step(1);
            k++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        wptr_gry_async = '0;
        ready = 1'b0;
        clr_err = 1'b0;
        #12;
        chk("rst_valid", 64'(valid), 64'(0));
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_rptr_gry", 64'(rptr_gry), 64'(0));
        chk("rst_occ", 64'(occ), 64'(0));
        chk("rst_data", 64'(data), 64'(0));
        chk("rst_rd_en", 64'(mem_rd_en), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        mon_en = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_rd_en", 64'(mem_rd_en), 64'(0));
            chk("idle_valid", 64'(valid), 64'(0));
        end
        step(1);

        // Four committed words stream back-to-back.
        put(1, 0); put(0, 0); put(0, 0); put(0, 1);
        publish();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rd_hist[i]  = mem_rd_en;
            val_hist[i] = valid;
        end
        step(1);
        chk("t2_rd_pattern", 64'(rd_hist), 64'(8'h3C));
        chk("t2_valid_pattern", 64'(val_hist), 64'(8'hF0));
        chk("t2_rptr_gry", 64'(rptr_gry), 64'(8'h06));
        chk("t2_empty", 64'(empty), 64'(1));
        chk("t2_occ", 64'(occ), 64'(0));

        // Backpressure: only the prefetch depth is read ahead.
        ready = 1'b0;
        put(1, 0);
        for (int i = 0; i < 6; i++) put(0, 0);
        put(0, 1);
        rd_cnt = 0;
        publish();
        step(6);
        chk("t3_reads", 64'(rd_cnt), 64'(2));
        chk("t3_occ", 64'(occ), 64'(6));
        chk("t3_valid", 64'(valid), 64'(1));
        chk("t3_head", 64'(data), 64'(exp_q[0].d));
        step(4);
        chk("t3_hold", 64'(data), 64'(exp_q[0].d));
        chk("t3_reads_hold", 64'(rd_cnt), 64'(2));
        ready = 1'b1;
        pop_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            val_hist[i] = valid;
        end
        step(1);
        chk("t3_stream", 64'(val_hist), 64'(8'hFF));
        chk("t3_pops", 64'(pop_cnt), 64'(8));

        // Bring both pointers to 250, then commit across the wrap.
        for (int i = 0; i < 238; i++) put(1, 1);
        publish();
        drain(400);
        chk("t4_rptr250", 64'(rptr_gry), 64'(8'd250 ^ (8'd250 >> 1)));
        put(1, 0);
        for (int i = 0; i < 8; i++) put(0, 0);
        put(0, 1);
        publish();
        for (int k = 0; k < 8 && empty; k++) @(negedge clk);
        chk("t4_occ10", 64'(occ), 64'(10));
        step(1);
        drain(50);
        chk("t4_rptr_gry", 64'(rptr_gry), 64'(8'h06));
        chk("t4_occ0", 64'(occ), 64'(0));

        // Framing error on a second SOP, cleared, then a clean packet.
        put(1, 0); put(0, 0); put(1, 0); put(0, 1);
        publish();
        drain(50);
        chk("t5_err_set", 64'(frm_err), 64'(1));
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        chk("t5_err_clr", 64'(frm_err), 64'(0));
        put(1, 0); put(0, 1);
        publish();
        drain(50);
        chk("t5_clean", 64'(frm_err), 64'(0));

        // Randomized traffic with backpressure and occasional clears.
        for (int c = 0; c < 400; c++) begin
            ready   = ($urandom_range(0, 3) != 0);
            clr_err = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0 && exp_q.size() < 200) begin
                int n = $urandom_range(1, 6);
                for (int j = 0; j < n; j++)
                    put(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
                publish();
            end
            step(1);
        end
        clr_err = 1'b0;
        drain(600);

        // Reset in the middle of a packet.
        put(0, 0);
        publish();
        drain(50);
        chk("t6_pre_err", 64'(frm_err), 64'(1));
        ready = 1'b0;
        put(1, 0); put(0, 0);
        publish();
        for (int k = 0; k < 10 && !valid; k++) step(1);
        chk("t6_valid_before", 64'(valid), 64'(1));
        mon_en = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 64'(valid), 64'(0));
        chk("t6_frm_err", 64'(frm_err), 64'(0));
        chk("t6_rptr_gry", 64'(rptr_gry), 64'(0));
        chk("t6_data", 64'(data), 64'(0));
        wptr_gry_async = '0;
        exp_q.delete();
        wbin = '0;
        exp_raddr = '0;
        prev_gry = '0;
        exp_frm = 1'b0;
        in_pkt = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        mon_en = 1'b1;
        put(1, 1);
        publish();
        drain(50);
        chk("t6_after_idle", 64'(frm_err), 64'(0));
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pkt_ff_rptr.md
Name: pkt_ff_rptr

Overview:
Read-side pointer and egress logic for the async packet FIFO; the read-domain counterpart of the write-pointer block.
- Synchronizes the write-domain gray write pointer and derives empty/occupancy.
- Drives the dual-port RAM read port (1-cycle read latency).
- Presents packet words on a valid/ready interface through a 2-entry prefetch buffer.
- Returns its own gray read pointer to the write domain for full computation.

Parameters:
PTR_W, 8, pointer/address width; RAM depth 2^PTR_W.
DATA_W, 32, data word width.

Ports:
clk  in  1  read-domain clock.
rst_n  in  1  asynchronous, active-low reset.
wptr_gry_async  in  PTR_W  gray write pointer from write domain; committed pointer, only moves forward.
rptr_gry  out  PTR_W  registered gray read pointer to write domain.
mem_rd_en  out  1  RAM read strobe.
mem_rd_addr  out  PTR_W  RAM read address (binary).
mem_rd_data  in  DATA_W  RAM data, valid 1 clk after mem_rd_en.
mem_rd_sop  in  1  stored SOP flag, same timing as mem_rd_data.
mem_rd_eop  in  1  stored EOP flag, same timing as mem_rd_data.
valid  out  1  egress word valid.
sop  out  1  egress start of packet.
eop  out  1  egress end of packet.
data  out  DATA_W  egress data.
ready  in  1  consumer accept.
empty  out  1  no unread words in RAM (sync'd view).
occ  out  PTR_W  RAM occupancy = wptr_bin - rptr_bin mod 2^PTR_W.
frm_err  out  1  sticky framing error.
clr_err  in  1  clears frm_err.

Behaviour:
Reset: all flops clear.
- rptr_bin = 0, rptr_gry = 0, sync stages = 0.
- valid = 0, sop = eop = 0, data = 0.
- mem_rd_en = 0, frm_err = 0, FSM = IDLE.
- empty = 1, occ = 0.

Write-pointer sync:
- 2-flop synchronizer on wptr_gry_async.
- Gray-to-binary conversion gives wptr_bin.
- Write-to-visible latency: 2 clk plus the source register.

Empty and occupancy:
- empty = (wptr_bin == rptr_bin); occ = wptr_bin - rptr_bin, PTR_W bits, wrapping.
- Both are combinational from the sync'd pointer and rptr_bin.

Read issue:
- mem_rd_en = ~empty & (buf_cnt + inflight - pop < 2), where pop = valid & ready.
- mem_rd_addr = rptr_bin.
- rptr_bin increments on every mem_rd_en, wrapping 2^PTR_W-1 -> 0.
- rptr_gry = registered bin2gray(rptr_bin); only one bit changes per increment.

Prefetch buffer:
- 2-entry FIFO of {sop, eop, data}.
- Written 1 clk after mem_rd_en (inflight flag).
- Head drives valid/sop/eop/data.
- Pop when valid & ready.
- Simultaneous write and pop is allowed; sustained throughput is 1 word/clk.
- Never overflows, guaranteed by the issue rule.
- Output fields hold stable while valid & ~ready.

Latency: word visible in sync'd wptr -> valid asserted after 2 clk (issue + RAM).

Framing FSM, advanced on each pop:
- IDLE: sop&eop -> IDLE; sop&~eop -> IN_PKT; ~sop -> set frm_err, stay IDLE.
- IN_PKT: eop&~sop -> IDLE; ~sop&~eop -> IN_PKT; sop -> set frm_err, restart packet (-> IDLE if eop else IN_PKT).
- Words are always passed through unmodified.

Error handling:
- frm_err is sticky.
- clr_err clears it; a new error in the same cycle as clr_err wins (frm_err = 1).

Boundaries:
- empty with ready high: valid stays 0, no RAM read.
- wptr jumps by more than 1 (burst commit): reads continue back-to-back until empty.
- Pointer wrap: occ is correct across the 255 -> 0 wrap (PTR_W = 8).
- Reset mid-packet: buffer and FSM cleared; the write side must be reset together.

Test Plan:
1. Reset, wptr_gry_async = 0 -> empty = 1, valid = 0, rptr_gry = 0, mem_rd_en never asserted.
2. Write domain commits 4 words (bin 0 -> 4, gray 0x06), ready = 1 -> mem_rd_en 4 consecutive clks at addr 0..3; valid high 4 consecutive clks; rptr_gry ends at 0x06; empty = 1, occ = 0.
3. 8 committed words, ready = 0 -> exactly 2 reads issued, occ = 6, valid held with stable data. Then ready = 1 -> remaining 6 words stream at 1/clk, in order, no loss or duplication.
4. rptr = wptr = 250, commit 10 words -> occ = 10; addresses 250..255, 0..3; final rptr_bin = 4; each rptr_gry transition flips exactly 1 bit.
5. Stored sequence sop, mid, sop, eop -> frm_err = 1 on the second sop's pop, all 4 words delivered. clr_err pulse -> frm_err = 0. Clean sop/eop packet afterwards -> frm_err stays 0.
6. rst_n asserted while valid = 1 mid-packet -> valid, frm_err, rptr_gry = 0 immediately (async); FSM IDLE after release.
